conv2d_stream: RTL and testbench

Streaming 2-D convolution engine: accepts an IMG_H×IMG_W frame of signed pixels in raster order over a valid/ready handshake. It buffers K-1 lines internally and emits one signed convolution result for every valid (unpadded) K×K window position at the configured stride. This is the parametrised successor of the fixed 3×3-on-5×5 parallel convolver. The whole image is no longer presented as one bus. Kernel size, stride, image size and data width are parameters, and the engine supports backpressure and frame sequencing.

---
 rtl/conv2d_stream_pkg.sv | 20 ++
 rtl/line_buffer.sv | 44 ++++
 rtl/conv2d_stream.sv | 206 ++++++++++++++++++++
 tb/tb_conv2d_stream.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv2d_stream_pkg.sv
// Shared types and helpers for the streaming 2-D convolution engine.
package conv2d_stream_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

    // Result width: full-precision product plus growth for summing k*k terms.
    function automatic int unsigned acc_width(input int unsigned width, input int unsigned k);
        return 2 * width + $clog2(k * k);
    endfunction

    function automatic int unsigned coef_idx(input int unsigned k, input int unsigned r,
                                             input int unsigned c);
        return k * r + c;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Shift-register line store; each tap is the pixel from the same column 1..ROWS rows earlier.
module line_buffer #(
    parameter int unsigned DEPTH = 5,
    parameter int unsigned ROWS  = 2,
    parameter int unsigned WIDTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        en_i,
    input  logic [WIDTH-1:0]            data_i,
    output logic [ROWS-1:0][WIDTH-1:0]  taps_o
);

    localparam int unsigned LEN = DEPTH * ROWS;

    logic [WIDTH-1:0] sr_q [LEN];
    logic [WIDTH-1:0] sr_d [LEN];

    always_comb begin
        sr_d = sr_q;
        if (en_i) begin
            sr_d[0] = data_i;
            for (int unsigned i = 1; i < LEN; i++) begin
                sr_d[i] = sr_q[i - 1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q <= '{default: '0};
        end else begin
            sr_q <= sr_d;
        end
    end

    // Taps are read before the shift, so they align with the pixel being written.
    always_comb begin
        for (int unsigned j = 0; j < ROWS; j++) begin
            taps_o[j] = sr_q[(j + 1) * DEPTH - 1];
        end
    end

endmodule

// File: rtl/conv2d_stream.sv
// Streaming KxK convolution over a raster-order frame with valid/ready on both sides.
module conv2d_stream
    import conv2d_stream_pkg::*;
#(
    parameter int unsigned K       = 3,
    parameter int unsigned STRIDE  = 1,
    parameter int unsigned IMG_W   = 5,
    parameter int unsigned IMG_H   = 5,
    parameter int unsigned WIDTH   = 4,
    localparam int unsigned ACC_W  = acc_width(WIDTH, K)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [K*K*WIDTH-1:0]        filter,
    input  logic                        filter_load,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [WIDTH-1:0]     in_pixel,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [ACC_W-1:0]     out_data,
    output logic                        out_last,
    output logic                        frame_done
);

    localparam int unsigned NT     = K * K;
    localparam int unsigned PW     = 2 * WIDTH;
    localparam int unsigned RW     = $clog2(IMG_H);
    localparam int unsigned CW     = $clog2(IMG_W);
    localparam int unsigned R_LAST = K - 1 + ((IMG_H - K) / STRIDE) * STRIDE;
    localparam int unsigned C_LAST = K - 1 + ((IMG_W - K) / STRIDE) * STRIDE;

    state_e                  state_q, state_d;
    logic [RW-1:0]           row_q, row_d;
    logic [CW-1:0]           col_q, col_d;
    logic signed [WIDTH-1:0] coef_q [NT];
    logic signed [WIDTH-1:0] coef_d [NT];
    logic signed [WIDTH-1:0] win_q  [NT];
    logic signed [WIDTH-1:0] win_d  [NT];
    logic signed [PW-1:0]    prod_w [NT];
    logic signed [PW-1:0]    prod_q [NT];
    logic signed [PW-1:0]    prod_d [NT];
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] out_data_q, out_data_d;
    logic s0_valid_q, s0_valid_d, s0_last_q, s0_last_d;
    logic s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
    logic out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic frame_done_q, frame_done_d, last_acked_q, last_acked_d;
    logic en_q;
    logic [K-2:0][WIDTH-1:0] taps;
    logic stall, accept, out_hs, at_last_pix, at_last_win, win_ok;

    assign stall       = out_valid_q && !out_ready;
    assign in_ready    = en_q && (state_q != StDrain) && !stall;
    assign accept      = in_valid && in_ready;
    assign out_hs      = out_valid_q && out_ready;
    assign at_last_pix = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
    assign at_last_win = (row_q == RW'(R_LAST)) && (col_q == CW'(C_LAST));
    assign win_ok      = (32'(row_q) >= K - 1) && (32'(col_q) >= K - 1)
                      && ((32'(row_q) - (K - 1)) % STRIDE == 0)
                      && ((32'(col_q) - (K - 1)) % STRIDE == 0);

    line_buffer #(
        .DEPTH (IMG_W),
        .ROWS  (K - 1),
        .WIDTH (WIDTH)
    ) u_line_buffer (
        .clk_i  (clk),
        .rst_ni (reset),
        .en_i   (accept),
        .data_i (in_pixel),
        .taps_o (taps)
    );

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        coef_d       = coef_q;
        frame_done_d = 1'b0;
        last_acked_d = last_acked_q || (out_hs && out_last_q);
        if (state_q == StIdle && filter_load) begin
            for (int unsigned i = 0; i < NT; i++) begin
                coef_d[i] = filter[i*WIDTH +: WIDTH];
            end
        end
        if (accept) begin
            if (at_last_pix) begin
                row_d   = '0;
                col_d   = '0;
                state_d = StDrain;
            end else begin
                state_d = StRun;
                if (col_q == CW'(IMG_W - 1)) begin
                    col_d = '0;
                    row_d = row_q + RW'(1);
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
        end
        case (state_q)
            StDrain: begin
                // With coarse strides the last result can be accepted before DRAIN is reached.
                if (last_acked_q || (out_hs && out_last_q)) begin
                    state_d      = StIdle;
                    frame_done_d = 1'b1;
                    last_acked_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Window columns shift left; the new column is the pixel plus the line-buffer taps.
    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int unsigned r = 0; r < K; r++) begin
                for (int unsigned c = 0; c + 1 < K; c++) begin
                    win_d[coef_idx(K, r, c)] = win_q[coef_idx(K, r, c + 1)];
                end
            end
            win_d[coef_idx(K, K - 1, K - 1)] = in_pixel;
            for (int unsigned j = 1; j < K; j++) begin
                win_d[coef_idx(K, K - 1 - j, K - 1)] = $signed(taps[j - 1]);
            end
        end
    end

    for (genvar i = 0; i < NT; i++) begin : g_mul
        assign prod_w[i] = PW'(win_q[i]) * PW'(coef_q[i]);
    end

    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < NT; i++) begin
            sum = sum + ACC_W'(prod_q[i]);
        end
    end

    always_comb begin
        s0_valid_d  = s0_valid_q;
        s0_last_d   = s0_last_q;
        s1_valid_d  = s1_valid_q;
        s1_last_d   = s1_last_q;
        prod_d      = prod_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        if (!stall) begin
            s0_valid_d  = accept && win_ok;
            s0_last_d   = accept && win_ok && at_last_win;
            s1_valid_d  = s0_valid_q;
            s1_last_d   = s0_last_q;
            prod_d      = prod_w;
            out_valid_d = s1_valid_q;
            out_last_d  = s1_last_q;
            out_data_d  = sum;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            row_q        <= '0;
            col_q        <= '0;
            coef_q       <= '{default: '0};
            win_q        <= '{default: '0};
            prod_q       <= '{default: '0};
            s0_valid_q   <= 1'b0;
            s0_last_q    <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            frame_done_q <= 1'b0;
            last_acked_q <= 1'b0;
            en_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            coef_q       <= coef_d;
            win_q        <= win_d;
            prod_q       <= prod_d;
            s0_valid_q   <= s0_valid_d;
            s0_last_q    <= s0_last_d;
            s1_valid_q   <= s1_valid_d;
            s1_last_q    <= s1_last_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_data_q   <= out_data_d;
            frame_done_q <= frame_done_d;
            last_acked_q <= last_acked_d;
            en_q         <= 1'b1;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv2d_stream.sv
// Directed bench: defaults (WIDTH=4) for constant frames, WIDTH=6 for ramp frames (values to 24).
module tb_conv2d_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, filter_load, in_valid, out_ready;
    int   pix_val;
    int   sel;
    int   coef [9];
    int   expv [9];
    int   passed = 0;
    int   total  = 0;
    int   fails  = 0;

    logic [35:0] f4;
    logic [53:0] f6;
    logic signed [11:0] od0;
    logic signed [15:0] od1, od2;
    logic ir0, ir1, ir2, ov0, ov1, ov2, ol0, ol1, ol2, fd0, fd1, fd2;
    logic obs_ready, obs_valid, obs_last, obs_fd;
    logic signed [31:0] obs_data;

    always_comb begin
        f4 = '0;
        f6 = '0;
        for (int i = 0; i < 9; i++) begin
            f4[i*4 +: 4] = 4'(coef[i]);
            f6[i*6 +: 6] = 6'(coef[i]);
        end
    end

    always_comb begin
        case (sel)
            0: begin
                obs_ready = ir0; obs_valid = ov0; obs_last = ol0; obs_fd = fd0;
                obs_data = 32'(od0);
            end
            1: begin
                obs_ready = ir1; obs_valid = ov1; obs_last = ol1; obs_fd = fd1;
                obs_data = 32'(od1);
            end
            default: begin
                obs_ready = ir2; obs_valid = ov2; obs_last = ol2; obs_fd = fd2;
                obs_data = 32'(od2);
            end
        endcase
    end

    conv2d_stream dut0 (
        .clk         (clk),
        .reset       (reset),
        .filter      (f4),
        .filter_load (filter_load),
        .in_valid    (in_valid && sel == 0),
        .in_ready    (ir0),
        .in_pixel    (4'(pix_val)),
        .out_valid   (ov0),
        .out_ready   (sel == 0 ? out_ready : 1'b1),
        .out_data    (od0),
        .out_last    (ol0),
        .frame_done  (fd0)
    );

    conv2d_stream #(.WIDTH(6)) dut1 (
        .clk         (clk),
        .reset       (reset),
        .filter      (f6),
        .filter_load (filter_load),
        .in_valid    (in_valid && sel == 1),
        .in_ready    (ir1),
        .in_pixel    (6'(pix_val)),
        .out_valid   (ov1),
        .out_ready   (sel == 1 ? out_ready : 1'b1),
        .out_data    (od1),
        .out_last    (ol1),
        .frame_done  (fd1)
    );

    conv2d_stream #(.WIDTH(6), .STRIDE(2)) dut2 (
        .clk         (clk),
        .reset       (reset),
        .filter      (f6),
        .filter_load (filter_load),
        .in_valid    (in_valid && sel == 2),
        .in_ready    (ir2),
        .in_pixel    (6'(pix_val)),
        .out_valid   (ov2),
        .out_ready   (sel == 2 ? out_ready : 1'b1),
        .out_data    (od2),
        .out_last    (ol2),
        .frame_done  (fd2)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_all(input int v);
        for (int i = 0; i < 9; i++) coef[i] = v;
    endtask

    task automatic set_centre();
        for (int i = 0; i < 9; i++) coef[i] = (i == 4) ? 1 : 0;
    endtask

    function automatic int pix_of(input int mode, input int p);
        case (mode)
            0:       return 1;
            1:       return -8;
            2:       return 7;
            default: return p;
        endcase
    endfunction

    task automatic send_pixels(input int mode, input int stop_at, input bit load_first,
                               input bit run_load);
        bit acc;
        int guard;
        for (int p = 0; p < stop_at; p++) begin
            @(negedge clk);
            in_valid    = 1'b1;
            pix_val     = pix_of(mode, p);
            filter_load = (p == 0 && load_first) || (p == 10 && run_load);
            if (p == 10 && run_load) set_all(1);
            #2;
            acc   = obs_ready;
            guard = 0;
            while (!acc && guard < 200) begin
                @(negedge clk);
                filter_load = 1'b0;
                #2;
                acc = obs_ready;
                guard++;
            end
            check("pixel_accepted", 32'(acc), 1);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid    = 1'b0;
        filter_load = 1'b0;
    endtask

    task automatic collect(input int nexp, input bit rand_ready);
        int idx = 0;
        int cycles = 0;
        bit stalled;
        bit prev_stall = 1'b0;
        logic signed [31:0] prev_data = 0;
        logic prev_last = 1'b0;
        while (idx < nexp && cycles < 400) begin
            @(negedge clk);
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #2;
            stalled = obs_valid && !out_ready;
            if (prev_stall) begin
                check("hold_valid", 32'(obs_valid), 1);
                check("hold_data", obs_data, prev_data);
                check("hold_last", 32'(obs_last), 32'(prev_last));
            end
            if (stalled) check("stall_in_ready", 32'(obs_ready), 0);
            if (obs_valid && out_ready) begin
                check($sformatf("result[%0d]", idx), obs_data, expv[idx]);
                check($sformatf("last[%0d]", idx), 32'(obs_last), (idx == nexp - 1) ? 1 : 0);
                check($sformatf("fdone_early[%0d]", idx), 32'(obs_fd), 0);
                idx++;
            end
            prev_stall = stalled;
            prev_data  = obs_data;
            prev_last  = obs_last;
            @(posedge clk);
            cycles++;
        end
        check("result_count", idx, nexp);
        @(negedge clk);
        out_ready = 1'b1;
        #2;
        check("frame_done_pulse", 32'(obs_fd), 1);
        check("no_extra_valid", 32'(obs_valid), 0);
        @(negedge clk);
        #2;
        check("frame_done_clear", 32'(obs_fd), 0);
    endtask

    initial begin
        bit saw;
        reset       = 1'b0;
        filter_load = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        pix_val     = 0;
        sel         = 0;
        set_all(0);
        expv        = '{default: 0};

        @(negedge clk);
        #2;
        check("rst_in_ready", 32'(obs_ready), 0);
        check("rst_out_valid", 32'(obs_valid), 0);
        check("rst_out_data", obs_data, 0);
        check("rst_out_last", 32'(obs_last), 0);
        check("rst_frame_done", 32'(obs_fd), 0);
        @(negedge clk);
        reset = 1'b1;

        // Constant frames on the default configuration.
        set_all(1);
        expv = '{default: 9};
        fork send_pixels(0, 25, 1, 0); collect(9, 0); join

        set_all(-8);
        expv = '{default: 576};
        fork send_pixels(1, 25, 1, 0); collect(9, 0); join

        expv = '{default: -504};
        fork send_pixels(2, 25, 1, 0); collect(9, 0); join

        // Ramp with centre tap; a load attempt in RUN must be ignored.
        sel = 1;
        set_centre();
        expv = '{6, 7, 8, 11, 12, 13, 16, 17, 18};
        fork send_pixels(3, 25, 1, 1); collect(9, 0); join

        set_centre();
        fork send_pixels(3, 25, 1, 0); collect(9, 1); join

        sel = 2;
        expv = '{6, 8, 16, 18, 0, 0, 0, 0, 0};
        fork send_pixels(3, 25, 1, 0); collect(4, 0); join

        // Abort a frame mid-way with reset.
        sel = 1;
        set_centre();
        send_pixels(3, 14, 1, 0);
        @(negedge clk);
        reset = 1'b0;
        #2;
        check("midrst_out_valid", 32'(obs_valid), 0);
        check("midrst_in_ready", 32'(obs_ready), 0);
        check("midrst_out_data", obs_data, 0);
        check("midrst_out_last", 32'(obs_last), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            #2;
            if (obs_valid) saw = 1'b1;
        end
        check("post_reset_no_valid", 32'(saw), 0);

        // Coefficients were cleared by reset, so an unloaded frame yields zeros.
        expv = '{default: 0};
        fork send_pixels(0, 25, 0, 0); collect(9, 0); join

        expv = '{6, 7, 8, 11, 12, 13, 16, 17, 18};
        fork send_pixels(3, 25, 1, 0); collect(9, 0); join

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
